hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX/MEM forwarding selectors in the 5-stage WISC-SP22 pipeline.
- Tracks in-flight register writes, one shadow entry per stage (EX, MEM, WB), as they leave ID.
- Detects load-use hazards that forwarding cannot cover and stalls ID with a single-cycle bubble.
- Exports a pending-write mask and a saturating load-use stall counter for debug and performance.

Parameters:
- CNT_W, 16, width of the load-use stall counter.
- NREG, 8, architectural register count; the pending mask is NREG bits wide.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (not a NOP or squashed slot)
- id_regwrite  in  1  ID instruction writes a register
- id_memread  in  1  ID instruction is a load (LD)
- id_link  in  1  ID instruction links (JAL/JALR); its destination is forced to R7
- id_wreg  in  3  ID destination register before the link override
- id_use1, id_use2  in  1 each  ID instruction actually reads rs1 / rs2
- id_rs1, id_rs2  in  3 each  ID source register selects
- flush  in  1  branch/jump redirect; squashes the ID instruction
- ext_stall  in  1  memory stall; freezes the whole pipeline
- stall_id  out  1  hold PC and IF/ID; combinational
- bubble_ex  out  1  EX currently holds a bubble injected by this block; registered
- pending_mask  out  NREG  bit r set when any valid shadow entry writes Rr; combinational from state
- loaduse_count  out  CNT_W  number of load-use stall cycles, saturating
- busy  out  1  any shadow entry is valid

Behaviour:
- State: three entries E, M, W, each holding {v, wr, ld, dest[2:0]}.
- Reset (async, rst_n low): all entries cleared to v=0, wr=0, ld=0, dest=0. bubble_ex=0, loaduse_count=0. As a result stall_id=0, pending_mask=0, busy=0.
- Effective destination: id_dest = id_link ? 3'b111 : id_wreg. Entering wr = id_regwrite | id_link.
- Hazard:
  - hz = id_valid & ~flush & E.v & E.wr & E.ld & ((id_use1 & id_rs1==E.dest) | (id_use2 & id_rs2==E.dest)).
  - stall_id = hz.
  - A match on M or W never stalls; forwarding and the register-file bypass cover those cases.
- Clock edge, ext_stall=1: all state holds, including bubble_ex and the counter. stall_id is still driven from the current state.
- Clock edge, ext_stall=0:
  - W <= M; M <= E.
  - If hz, flush, or ~id_valid: E <= empty (v=0). bubble_ex <= hz.
  - Otherwise: E <= {1, wr, id_memread, id_dest}. bubble_ex <= 0.
- Latency: a load followed by a dependent instruction produces exactly one stall cycle. On the next cycle the load sits in M, so hz=0 and the dependent instruction proceeds using MEM-EX forwarding.
- hz and flush in the same cycle: flush wins. hz is masked, so there is no stall and no count.
- Counter: increments by 1 on each edge where hz & ~ext_stall. It holds at all-ones; it never wraps.
- pending_mask: OR of one-hot(dest) over entries with v & wr. Duplicate destinations collapse to a single bit.
- R0 is an ordinary register in this ISA and is tracked like any other.
- busy = E.v | M.v | W.v. Used by the HALT drain logic.
- Reset asserted mid-operation clears all state immediately. There is no recovery of in-flight entries.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> stall_id=0, pending_mask=0, loaduse_count=0, busy=0. Release reset -> all outputs unchanged until the first valid ID.
- LD R3 then ADD R1,R3,R2 (use1=1, rs1=3) -> stall_id=1 for exactly one cycle, bubble_ex=1 on the following cycle, loaduse_count=1. The next cycle has stall_id=0.
- LD R3 then ST R2,R3 (use2=1, rs2=3) -> one stall. LD R3 then an instruction with rs1=3 but use1=0 -> no stall, counter unchanged.
- LD R5, then ADDI R1,R5 issued with an intervening unrelated instruction -> stall_id stays 0. pending_mask goes 0x20, then 0x22, and returns to 0 after the entries drain.
- JAL (id_link=1, id_wreg=3'b010) -> pending_mask=0x80, not 0x04. A load into R7 followed by JR R7 -> one stall.
- Hazard while ext_stall=1 for 4 cycles -> stall_id=1 throughout, counter +1 only on the edge where ext_stall drops. Hazard with flush=1 -> no stall, E becomes empty. Preload the counter to 0xFFFF via 65535 hazards -> one more hazard leaves it at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue/hazard bus between the pipeline control and the hazard scoreboard.
// The pipeline side is the master; the scoreboard side is the slave.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16,
  parameter int NREG  = 8
);
  logic             id_valid;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_link;
  logic [2:0]       id_wreg;
  logic             id_use1;
  logic             id_use2;
  logic [2:0]       id_rs1;
  logic [2:0]       id_rs2;
  logic             flush;
  logic             ext_stall;

  logic             stall_id;
  logic             bubble_ex;
  logic [NREG-1:0]  pending_mask;
  logic [CNT_W-1:0] loaduse_count;
  logic             busy;

  modport master (
    output id_valid, id_regwrite, id_memread, id_link, id_wreg,
           id_use1, id_use2, id_rs1, id_rs2, flush, ext_stall,
    input  stall_id, bubble_ex, pending_mask, loaduse_count, busy
  );

  modport slave (
    input  id_valid, id_regwrite, id_memread, id_link, id_wreg,
           id_use1, id_use2, id_rs1, id_rs2, flush, ext_stall,
    output stall_id, bubble_ex, pending_mask, loaduse_count, busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of in-flight register writes (EX/MEM/WB) for the 5-stage pipeline.
// Stalls ID one cycle on an uncoverable load-use hazard and counts those stalls.
module hazard_scoreboard #(
  parameter int CNT_W = 16,
  parameter int NREG  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [2:0] dest;
  } entry_t;

  localparam int NSTG  = 3;
  localparam int E_IDX = 0;
  localparam int M_IDX = 1;
  localparam int W_IDX = 2;

  entry_t [NSTG-1:0] ent_q;
  entry_t [NSTG-1:0] ent_d;
  logic              bubble_q;
  logic              bubble_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [2:0]        id_dest;
  logic              id_wr;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              hz;
  logic              e_is_load;
  entry_t            id_entry;

  always_comb begin
    id_dest   = bus.id_link ? 3'b111 : bus.id_wreg;
    id_wr     = bus.id_regwrite | bus.id_link;
    e_is_load = ent_q[E_IDX].v & ent_q[E_IDX].wr & ent_q[E_IDX].ld;
    rs1_hit   = bus.id_use1 & (bus.id_rs1 == ent_q[E_IDX].dest);
    rs2_hit   = bus.id_use2 & (bus.id_rs2 == ent_q[E_IDX].dest);
    // Only a load still in EX is uncoverable; flush masks the hazard entirely.
    hz        = bus.id_valid & ~bus.flush & e_is_load & (rs1_hit | rs2_hit);

    id_entry      = '0;
    id_entry.v    = 1'b1;
    id_entry.wr   = id_wr;
    id_entry.ld   = bus.id_memread;
    id_entry.dest = id_dest;
  end

  always_comb begin
    ent_d    = ent_q;
    bubble_d = bubble_q;
    cnt_d    = cnt_q;
    if (!bus.ext_stall) begin
      ent_d[W_IDX] = ent_q[M_IDX];
      ent_d[M_IDX] = ent_q[E_IDX];
      if (hz || bus.flush || !bus.id_valid) begin
        ent_d[E_IDX] = '0;
      end else begin
        ent_d[E_IDX] = id_entry;
      end
      bubble_d = hz;
      if (hz && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q    <= '0;
      bubble_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  // One pending bit per architectural register; registers past R7 are never addressed.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_mask
      if (gi < 8) begin : g_addr
        logic [NSTG-1:0] hit;
        genvar gj;
        for (gj = 0; gj < NSTG; gj++) begin : g_stage
          assign hit[gj] = ent_q[gj].v & ent_q[gj].wr & (ent_q[gj].dest == 3'(gi));
        end
        assign bus.pending_mask[gi] = |hit;
      end else begin : g_none
        assign bus.pending_mask[gi] = 1'b0;
      end
    end
  endgenerate

  assign bus.stall_id      = hz;
  assign bus.bubble_ex     = bubble_q;
  assign bus.loaduse_count = cnt_q;
  assign bus.busy          = ent_q[E_IDX].v | ent_q[M_IDX].v | ent_q[W_IDX].v;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, random traffic
// against a queue-based reference model, counter saturation and async reset.
module tb_hazard_scoreboard;

  localparam int CW   = 8;
  localparam int NR   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  hazard_scoreboard_if #(.CNT_W(CW), .NREG(NR)) bus ();

  hazard_scoreboard #(.CNT_W(CW), .NREG(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v, rw, mr, lk;
    int wr;
    bit u1;
    int r1;
    bit u2;
    int r2;
    bit fl, xs;
    bit e_st, e_bu;
    int e_mk, e_cn;
    bit e_by;
  } vec_t;

  typedef struct {
    bit v, wr, ld;
    int dest;
  } slot_t;

  int checks   = 0;
  int failures = 0;

  // Reference: list of the three most recently issued slots, youngest first.
  slot_t pipe[$];
  bit    m_bubble;
  int    m_cnt;

  vec_t tbl[$];

  function automatic vec_t V(bit v, bit rw, bit mr, bit lk, int wr,
                             bit u1, int r1, bit u2, int r2, bit fl, bit xs,
                             bit st, bit bu, int mk, int cn, bit by);
    vec_t t;
    t.v = v; t.rw = rw; t.mr = mr; t.lk = lk; t.wr = wr;
    t.u1 = u1; t.r1 = r1; t.u2 = u2; t.r2 = r2; t.fl = fl; t.xs = xs;
    t.e_st = st; t.e_bu = bu; t.e_mk = mk; t.e_cn = cn; t.e_by = by;
    return t;
  endfunction

  function automatic vec_t N(int mk, int cn, bit by);
    return V(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, mk, cn, by);
  endfunction

  function automatic vec_t LD(int rd, int mk, int cn, bit by);
    return V(1,1,1,0,rd, 0,0,0,0, 0,0, 0,0, mk, cn, by);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    slot_t e;
    e = '{v:0, wr:0, ld:0, dest:0};
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_bubble = 0;
    m_cnt    = 0;
  endtask

  function automatic bit model_hz(vec_t t);
    slot_t e;
    e = pipe[0];
    if (!t.v || t.fl || !(e.v && e.wr && e.ld)) return 0;
    return (t.u1 && t.r1 == e.dest) || (t.u2 && t.r2 == e.dest);
  endfunction

  function automatic int model_mask();
    int m;
    m = 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].wr) m |= (1 << pipe[i].dest);
    return m;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = 0;
    foreach (pipe[i]) b |= pipe[i].v;
    return b;
  endfunction

  task automatic model_clock(vec_t t);
    slot_t n;
    bit    h;
    if (t.xs) return;
    h = model_hz(t);
    n = '{v:0, wr:0, ld:0, dest:0};
    if (!(h || t.fl || !t.v)) n = '{v:1, wr:(t.rw | t.lk), ld:t.mr, dest:(t.lk ? 7 : t.wr)};
    pipe.push_front(n);
    void'(pipe.pop_back());
    m_bubble = h;
    if (h && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic drive(vec_t t);
    bus.id_valid    = t.v;
    bus.id_regwrite = t.rw;
    bus.id_memread  = t.mr;
    bus.id_link     = t.lk;
    bus.id_wreg     = 3'(t.wr);
    bus.id_use1     = t.u1;
    bus.id_rs1      = 3'(t.r1);
    bus.id_use2     = t.u2;
    bus.id_rs2      = 3'(t.r2);
    bus.flush       = t.fl;
    bus.ext_stall   = t.xs;
  endtask

  task automatic check_model(vec_t t, string nm);
    chk({nm, ".stall"},  int'(bus.stall_id),      int'(model_hz(t)));
    chk({nm, ".bubble"}, int'(bus.bubble_ex),     int'(m_bubble));
    chk({nm, ".mask"},   int'(bus.pending_mask),  model_mask());
    chk({nm, ".count"},  int'(bus.loaduse_count), m_cnt);
    chk({nm, ".busy"},   int'(bus.busy),          int'(model_busy()));
  endtask

  task automatic check_zero(string nm);
    chk({nm, ".stall"},  int'(bus.stall_id),      0);
    chk({nm, ".bubble"}, int'(bus.bubble_ex),     0);
    chk({nm, ".mask"},   int'(bus.pending_mask),  0);
    chk({nm, ".count"},  int'(bus.loaduse_count), 0);
    chk({nm, ".busy"},   int'(bus.busy),          0);
  endtask

  // Called at a negedge: drive, check away from the edge, clock, advance the model.
  task automatic step(vec_t t, bit use_tbl, string nm);
    drive(t);
    #1;
    check_model(t, nm);
    if (use_tbl) begin
      chk({nm, ".tstall"},  int'(bus.stall_id),      int'(t.e_st));
      chk({nm, ".tbubble"}, int'(bus.bubble_ex),     int'(t.e_bu));
      chk({nm, ".tmask"},   int'(bus.pending_mask),  t.e_mk);
      chk({nm, ".tcount"},  int'(bus.loaduse_count), t.e_cn);
      chk({nm, ".tbusy"},   int'(bus.busy),          int'(t.e_by));
    end
    $display("step %s v=%0b ld=%0b wr=%0d rs1=%0d/%0b rs2=%0d/%0b fl=%0b xs=%0b -> stall=%0b bub=%0b mask=%02h cnt=%0d busy=%0b",
             nm, t.v, t.mr, t.wr, t.r1, t.u1, t.r2, t.u2, t.fl, t.xs,
             bus.stall_id, bus.bubble_ex, bus.pending_mask, bus.loaduse_count, bus.busy);
    @(posedge clk);
    model_clock(t);
    @(negedge clk);
  endtask

  function automatic vec_t rand_vec(bit allow_xs);
    vec_t t;
    t = N(0, 0, 0);
    t.v  = ($urandom_range(0, 9) < 8);
    t.rw = $urandom_range(0, 1);
    t.mr = ($urandom_range(0, 9) < 4);
    t.lk = ($urandom_range(0, 9) == 0);
    t.wr = $urandom_range(0, 3);
    t.u1 = $urandom_range(0, 1);
    t.r1 = $urandom_range(0, 3);
    t.u2 = $urandom_range(0, 1);
    t.r2 = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
    t.fl = ($urandom_range(0, 9) == 0);
    t.xs = allow_xs && ($urandom_range(0, 6) == 0);
    return t;
  endfunction

  initial begin
    vec_t t;
    int   guard;

    // Directed sequence; expectations are observed before each row's clock edge.
    tbl.push_back(N('h00,0,0));
    tbl.push_back(LD(3,'h00,0,0));
    tbl.push_back(V(1,1,0,0,1, 1,3,1,2, 0,0, 1,0,'h08,0,1));
    tbl.push_back(V(1,1,0,0,1, 1,3,1,2, 0,0, 0,1,'h08,1,1));
    tbl.push_back(N('h0A,1,1));
    tbl.push_back(N('h02,1,1));
    tbl.push_back(N('h02,1,1));
    tbl.push_back(LD(3,'h00,1,0));
    tbl.push_back(V(1,0,0,0,0, 1,2,1,3, 0,0, 1,0,'h08,1,1));
    tbl.push_back(V(1,0,0,0,0, 1,2,1,3, 0,0, 0,1,'h08,2,1));
    tbl.push_back(LD(3,'h08,2,1));
    tbl.push_back(V(1,1,0,0,4, 0,3,0,0, 0,0, 0,0,'h08,2,1));
    tbl.push_back(N('h18,2,1));
    tbl.push_back(N('h18,2,1));
    tbl.push_back(N('h10,2,1));
    tbl.push_back(LD(5,'h00,2,0));
    tbl.push_back(V(1,1,0,0,1, 1,2,1,4, 0,0, 0,0,'h20,2,1));
    tbl.push_back(V(1,1,0,0,1, 1,5,0,0, 0,0, 0,0,'h22,2,1));
    tbl.push_back(N('h22,2,1));
    tbl.push_back(N('h02,2,1));
    tbl.push_back(N('h02,2,1));
    tbl.push_back(N('h00,2,0));
    tbl.push_back(V(1,0,0,1,2, 0,0,0,0, 0,0, 0,0,'h00,2,0));
    tbl.push_back(N('h80,2,1));
    tbl.push_back(N('h80,2,1));
    tbl.push_back(N('h80,2,1));
    tbl.push_back(LD(7,'h00,2,0));
    tbl.push_back(V(1,0,0,0,0, 1,7,0,0, 0,0, 1,0,'h80,2,1));
    tbl.push_back(V(1,0,0,0,0, 1,7,0,0, 0,0, 0,1,'h80,3,1));
    tbl.push_back(N('h80,3,1));
    tbl.push_back(N('h00,3,1));
    tbl.push_back(N('h00,3,1));
    tbl.push_back(LD(2,'h00,3,0));
    repeat (4) tbl.push_back(V(1,1,0,0,4, 1,2,0,0, 0,1, 1,0,'h04,3,1));
    tbl.push_back(V(1,1,0,0,4, 1,2,0,0, 0,0, 1,0,'h04,3,1));
    tbl.push_back(V(1,1,0,0,4, 1,2,0,0, 0,0, 0,1,'h04,4,1));
    tbl.push_back(N('h14,4,1));
    tbl.push_back(N('h10,4,1));
    tbl.push_back(N('h10,4,1));
    tbl.push_back(LD(6,'h00,4,0));
    tbl.push_back(V(1,1,0,0,1, 0,0,1,6, 1,0, 0,0,'h40,4,1));
    tbl.push_back(N('h40,4,1));
    tbl.push_back(N('h40,4,1));
    tbl.push_back(N('h00,4,0));
    tbl.push_back(LD(0,'h00,4,0));
    tbl.push_back(V(1,1,0,0,0, 0,0,1,0, 0,0, 1,0,'h01,4,1));
    tbl.push_back(V(1,1,0,0,0, 0,0,1,0, 0,0, 0,1,'h01,5,1));
    tbl.push_back(N('h01,5,1));

    // Reset held with random inputs: state stays clear.
    rst_n = 1'b0;
    model_reset();
    drive(N(0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(rand_vec(1));
      #1;
      check_zero($sformatf("rst%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // After release, invalid ID slots leave everything idle.
    for (int i = 0; i < 3; i++) begin
      t = rand_vec(0);
      t.v = 0;
      step(t, 0, $sformatf("idle%0d", i));
      check_zero($sformatf("idlez%0d", i));
    end

    foreach (tbl[i]) step(tbl[i], 1, $sformatf("vec%0d", i));

    // Saturation: drive load/use pairs until the counter pins at all-ones.
    guard = 0;
    while (m_cnt < CMAX && guard < 4 * CMAX) begin
      step(LD(1, 0, 0, 0), 0, "satld");
      step(V(1,1,0,0,2, 1,1,0,0, 0,0, 0,0,0,0,0), 0, "satuse");
      guard++;
    end
    chk("sat.reached", int'(bus.loaduse_count), CMAX);
    step(LD(1, 0, 0, 0), 0, "satld");
    chk("sat.hz", int'(bus.stall_id), 0);
    step(V(1,1,0,0,2, 1,1,0,0, 0,0, 0,0,0,0,0), 0, "satuse");
    chk("sat.hold", int'(bus.loaduse_count), CMAX);

    // Random traffic against the reference model.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) step(rand_vec(1), 0, $sformatf("rnd%0d", i));

    // Asynchronous reset mid-operation clears state without a clock edge.
    for (int i = 0; i < 4; i++) step(LD(i, 0, 0, 0), 0, $sformatf("prerst%0d", i));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) step(rand_vec(1), 0, $sformatf("post%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
